// File: rtl/poly_voice_alloc.sv
// Polyphonic voice allocator: maps MIDI note on/off events onto VOICES gate/note/velocity slots.
// Allocation order: retrigger the same note, else the oldest free voice, else steal the oldest gated voice.
module poly_voice_alloc #(
    parameter int VOICES    = 4,
    parameter int AGE_W     = 8,
    parameter int OMNI      = 0,
    parameter int MIDI_CHAN = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ev_on,
    input  logic                ev_off,
    input  logic [3:0]          ev_chan,
    input  logic [6:0]          ev_note,
    input  logic [6:0]          ev_vel,
    input  logic                all_off,
    output logic                busy,
    output logic                ev_drop,
    output logic                steal,
    output logic [VOICES-1:0]   voice_gate,
    output logic [VOICES-1:0]   voice_trig,
    output logic [7*VOICES-1:0] voice_note,
    output logic [7*VOICES-1:0] voice_vel
);
    localparam int IDX_W = $clog2(VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;
    state_t state, state_nxt;

    logic [6:0]       note_r [VOICES];
    logic [6:0]       vel_r  [VOICES];
    logic [AGE_W-1:0] age    [VOICES];
    logic [IDX_W-1:0] scan_idx;
    logic [6:0]       lat_note, lat_vel;
    logic             lat_on;
    logic             match_found, free_found, old_found;
    logic [IDX_W-1:0] match_idx, free_idx, old_idx, target_idx;
    logic [AGE_W-1:0] free_age, old_age;
    logic             chan_ok, ev_valid, is_on, target_ok, steal_sel;

    assign chan_ok  = (OMNI != 0) || (ev_chan == 4'(MIDI_CHAN));
    assign ev_valid = (ev_on || ev_off) && chan_ok;
    // note-on with zero velocity, or on+off together, both count as note-off
    assign is_on    = ev_on && !ev_off && (ev_vel != '0);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!all_off && ev_valid) state_nxt = SCAN;
            SCAN:    if (scan_idx == LAST_IDX) state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        target_ok  = 1'b1;
        steal_sel  = 1'b0;
        target_idx = old_idx;
        if (match_found)     target_idx = match_idx;
        else if (free_found) target_idx = free_idx;
        else if (old_found)  steal_sel  = 1'b1;
        else                 target_ok  = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            voice_gate  <= '0;
            voice_trig  <= '0;
            steal       <= 1'b0;
            ev_drop     <= 1'b0;
            scan_idx    <= '0;
            lat_note    <= '0;
            lat_vel     <= '0;
            lat_on      <= 1'b0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            free_age    <= '0;
            old_age     <= '0;
            for (int unsigned i = 0; i < VOICES; i++) begin
                note_r[i] <= '0;
                vel_r[i]  <= '0;
                age[i]    <= '0;
            end
        end else begin
            voice_trig <= '0;
            steal      <= 1'b0;
            ev_drop    <= 1'b0;
            case (state)
                IDLE: begin
                    if (all_off) begin
                        voice_gate <= '0;
                    end else if (ev_valid) begin
                        lat_note    <= ev_note;
                        lat_vel     <= ev_vel;
                        lat_on      <= is_on;
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                    end
                end
                SCAN: begin
                    // strict '>' keeps the lowest index on age ties
                    if (voice_gate[scan_idx]) begin
                        if (!match_found && note_r[scan_idx] == lat_note) begin
                            match_found <= 1'b1;
                            match_idx   <= scan_idx;
                        end
                        if (!old_found || age[scan_idx] > old_age) begin
                            old_found <= 1'b1;
                            old_idx   <= scan_idx;
                            old_age   <= age[scan_idx];
                        end
                    end else if (!free_found || age[scan_idx] > free_age) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                        free_age   <= age[scan_idx];
                    end
                    scan_idx <= scan_idx + 1'b1;
                end
                APPLY: begin
                    if (lat_on) begin
                        if (target_ok) begin
                            steal <= steal_sel;
                            for (int unsigned i = 0; i < VOICES; i++) begin
                                if (IDX_W'(i) == target_idx) begin
                                    voice_gate[i] <= 1'b1;
                                    voice_trig[i] <= 1'b1;
                                    note_r[i]     <= lat_note;
                                    vel_r[i]      <= lat_vel;
                                    age[i]        <= '0;
                                end else if (age[i] != '1) begin
                                    age[i] <= age[i] + 1'b1;
                                end
                            end
                        end
                    end else begin
                        for (int unsigned i = 0; i < VOICES; i++) begin
                            if (voice_gate[i] && note_r[i] == lat_note) voice_gate[i] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
            if (state != IDLE && ev_valid) ev_drop <= 1'b1;
        end
    end

    always_comb begin
        voice_note = '0;
        voice_vel  = '0;
        for (int unsigned i = 0; i < VOICES; i++) begin
            voice_note[7*i +: 7] = note_r[i];
            voice_vel[7*i +: 7]  = vel_r[i];
        end
    end

endmodule

// File: tb/tb_poly_voice_alloc.sv
// Directed self-checking bench for poly_voice_alloc (VOICES=4, channel 0 only).
module tb_poly_voice_alloc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ev_on = 1'b0, ev_off = 1'b0, all_off = 1'b0;
    logic [3:0]  ev_chan = '0;
    logic [6:0]  ev_note = '0, ev_vel = '0;
    logic        busy, ev_drop, steal;
    logic [3:0]  voice_gate, voice_trig;
    logic [27:0] voice_note, voice_vel;

    int n_chk  = 0;
    int n_pass = 0;

    poly_voice_alloc #(.VOICES(4), .AGE_W(8), .OMNI(0), .MIDI_CHAN(0)) dut (
        .clk(clk), .rst(rst), .ev_on(ev_on), .ev_off(ev_off), .ev_chan(ev_chan),
        .ev_note(ev_note), .ev_vel(ev_vel), .all_off(all_off), .busy(busy),
        .ev_drop(ev_drop), .steal(steal), .voice_gate(voice_gate), .voice_trig(voice_trig),
        .voice_note(voice_note), .voice_vel(voice_vel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [6:0] note_of(input int i);
        return voice_note[7*i +: 7];
    endfunction

    function automatic logic [6:0] vel_of(input int i);
        return voice_vel[7*i +: 7];
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // One-cycle strobe; returns #1 after the sampling edge (cycle T+1)
    task automatic send(input logic on, input logic off, input logic [3:0] ch,
                        input logic [6:0] note, input logic [6:0] vel, input logic ao);
        @(posedge clk); #1;
        ev_on = on; ev_off = off; ev_chan = ch; ev_note = note; ev_vel = vel; all_off = ao;
        @(posedge clk); #1;
        ev_on = 1'b0; ev_off = 1'b0; all_off = 1'b0;
    endtask

    // Note-on, then check trig is silent at T+5, fires at T+6 and is gone at T+7
    task automatic note_on(input string tag, input logic [6:0] note, input logic [3:0] exp_trig,
                           input logic exp_steal);
        send(1'b1, 1'b0, 4'd0, note, 7'd100, 1'b0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        repeat (4) @(posedge clk);
        #1 check({tag, "_trig_early"}, 32'(voice_trig), 32'd0);
        @(posedge clk);
        #1 check({tag, "_trig"}, 32'(voice_trig), 32'(exp_trig));
        check({tag, "_steal"}, 32'(steal), 32'(exp_steal));
        @(posedge clk);
        #1 check({tag, "_trig_late"}, 32'(voice_trig), 32'd0);
        check({tag, "_steal_late"}, 32'(steal), 32'd0);
    endtask

    task automatic settle();
        repeat (7) @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        #1;
        check("rst_gate", 32'(voice_gate), 32'd0);
        check("rst_trig", 32'(voice_trig), 32'd0);
        check("rst_note", 32'(voice_note), 32'd0);
        check("rst_vel", 32'(voice_vel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({steal, ev_drop}), 32'd0);

        // 1: three notes land on voices 0,1,2
        note_on("t1_on60", 7'd60, 4'b0001, 1'b0);
        repeat (3) @(posedge clk);
        note_on("t1_on64", 7'd64, 4'b0010, 1'b0);
        repeat (3) @(posedge clk);
        note_on("t1_on67", 7'd67, 4'b0100, 1'b0);
        check("t1_gate", 32'(voice_gate), 32'b0111);
        check("t1_note0", 32'(note_of(0)), 32'd60);
        check("t1_note1", 32'(note_of(1)), 32'd64);
        check("t1_note2", 32'(note_of(2)), 32'd67);
        check("t1_vel0", 32'(vel_of(0)), 32'd100);

        // 2: fill all four, fifth note steals voice 0
        do_reset();
        note_on("t2_on60", 7'd60, 4'b0001, 1'b0);
        note_on("t2_on62", 7'd62, 4'b0010, 1'b0);
        note_on("t2_on64", 7'd64, 4'b0100, 1'b0);
        note_on("t2_on65", 7'd65, 4'b1000, 1'b0);
        note_on("t2_on67", 7'd67, 4'b0001, 1'b1);
        check("t2_gate", 32'(voice_gate), 32'b1111);
        check("t2_note0", 32'(note_of(0)), 32'd67);
        check("t2_note1", 32'(note_of(1)), 32'd62);
        check("t2_note2", 32'(note_of(2)), 32'd64);
        check("t2_note3", 32'(note_of(3)), 32'd65);

        // 3: release 62, next note reuses that free voice
        send(1'b0, 1'b1, 4'd0, 7'd62, 7'd0, 1'b0);
        settle();
        check("t3_gate_off", 32'(voice_gate), 32'b1101);
        check("t3_note1_hold", 32'(note_of(1)), 32'd62);
        note_on("t3_on70", 7'd70, 4'b0010, 1'b0);
        check("t3_note1", 32'(note_of(1)), 32'd70);
        check("t3_gate", 32'(voice_gate), 32'b1111);

        // 4: same note twice retriggers voice 0
        do_reset();
        note_on("t4_on60a", 7'd60, 4'b0001, 1'b0);
        note_on("t4_on60b", 7'd60, 4'b0001, 1'b0);
        check("t4_gate", 32'(voice_gate), 32'b0001);

        // 5: vel 0 note-on releases; foreign channel ignored
        send(1'b1, 1'b0, 4'd0, 7'd60, 7'd0, 1'b0);
        settle();
        check("t5_vel0_gate", 32'(voice_gate), 32'b0000);
        check("t5_vel0_note", 32'(note_of(0)), 32'd60);
        send(1'b1, 1'b0, 4'd3, 7'd50, 7'd90, 1'b0);
        check("t5_ch3_busy", 32'(busy), 32'd0);
        settle();
        check("t5_ch3_gate", 32'(voice_gate), 32'b0000);

        // strobe while busy is dropped; the first event lands on the oldest free voice (1)
        send(1'b1, 1'b0, 4'd0, 7'd61, 7'd80, 1'b0);
        ev_on = 1'b1; ev_note = 7'd62; ev_vel = 7'd80;
        @(posedge clk); #1;
        ev_on = 1'b0;
        check("t5_drop", 32'(ev_drop), 32'd1);
        @(posedge clk); #1;
        check("t5_drop_pulse", 32'(ev_drop), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("t5_drop_trig", 32'(voice_trig), 32'b0010);
        check("t5_drop_gate", 32'(voice_gate), 32'b0010);
        check("t5_drop_note1", 32'(note_of(1)), 32'd61);
        settle();
        check("t5_drop_nochange", 32'(voice_gate), 32'b0010);

        // 6: all_off beats a coincident note-on
        send(1'b1, 1'b0, 4'd0, 7'd40, 7'd90, 1'b1);
        check("t6_ao_busy", 32'(busy), 32'd0);
        check("t6_ao_gate", 32'(voice_gate), 32'b0000);
        settle();
        check("t6_ao_gate_later", 32'(voice_gate), 32'b0000);
        check("t6_ao_note_hold", 32'(note_of(1)), 32'd61);

        // reset mid-scan aborts the pending note-on
        send(1'b1, 1'b0, 4'd0, 7'd55, 7'd90, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_note", 32'(voice_note), 32'd0);
        check("t6_rst_gate", 32'(voice_gate), 32'd0);
        settle();
        check("t6_rst_gate_later", 32'(voice_gate), 32'd0);
        check("t6_rst_trig", 32'(voice_trig), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
